// File: rtl/i2s_transceiver_if.sv
// Parallel sample handshake between the I2S transceiver and its upstream/downstream audio logic.
// The master side supplies DAC samples and consumes ADC samples; the transceiver is the slave.
interface i2s_transceiver_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] tx_left;
    logic [DATA_WIDTH-1:0] tx_right;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_left;
    logic [DATA_WIDTH-1:0] rx_right;
    logic                  rx_valid;

    modport master (
        output tx_left, tx_right,
        input  tx_ready, rx_left, rx_right, rx_valid
    );

    modport slave (
        input  tx_left, tx_right,
        output tx_ready, rx_left, rx_right, rx_valid
    );
endinterface

// File: rtl/i2s_transceiver.sv
// Philips I2S transceiver running in the mclk domain on divider-generated sclk/lrclk.
// RX deserialises sdin into left/right pairs; TX serialises DAC samples onto sdout.
module i2s_transceiver #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              lrclk,
    input  logic              sdin,
    output logic              sdout,
    i2s_transceiver_if.slave  bus
);
    localparam int CW = $clog2(DATA_WIDTH + 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (DATA_WIDTH > SLOT_WIDTH - 1) begin : g_bad_width
        $error("DATA_WIDTH must not exceed SLOT_WIDTH-1");
    end

    logic sclk_d;
    logic lrclk_d;
    logic rise;
    logic fall;
    logic lr_chg;
    logic left_start;

    assign rise       = sclk & ~sclk_d;
    assign fall       = ~sclk & sclk_d;
    assign lr_chg     = lrclk ^ lrclk_d;
    assign left_start = fall & lr_chg & ~lrclk;

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            sclk_d  <= 1'b0;
            lrclk_d <= 1'b0;
        end else begin
            sclk_d  <= sclk;
            lrclk_d <= lrclk;
        end
    end

    logic                  rx_lr;
    logic                  rx_ch;
    logic                  rx_synced;
    logic                  left_ok;
    logic                  rx_valid_q;
    logic [CW-1:0]         rx_cnt;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic [DATA_WIDTH-1:0] left_hold;
    logic [DATA_WIDTH-1:0] rx_left_q;
    logic [DATA_WIDTH-1:0] rx_right_q;
    logic [DATA_WIDTH-1:0] rx_word;

    assign rx_word = {rx_sr[DATA_WIDTH-2:0], sdin};

    // left_ok is cleared at every left delay bit, so a short left half never pairs with a right word
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            rx_lr      <= 1'b0;
            rx_ch      <= 1'b0;
            rx_synced  <= 1'b0;
            left_ok    <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_cnt     <= '0;
            rx_sr      <= '0;
            left_hold  <= '0;
            rx_left_q  <= '0;
            rx_right_q <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            if (rise) begin
                rx_lr <= lrclk;
                if (lrclk != rx_lr) begin
                    rx_cnt <= CNT_ONE;
                    rx_ch  <= lrclk;
                    if (!lrclk) begin
                        rx_synced <= 1'b1;
                        left_ok   <= 1'b0;
                    end
                end else if (rx_cnt != '0 && rx_cnt <= CNT_LAST) begin
                    rx_sr  <= rx_word;
                    rx_cnt <= rx_cnt + CNT_ONE;
                    if (rx_cnt == CNT_LAST) begin
                        if (!rx_ch && rx_synced) begin
                            left_hold <= rx_word;
                            left_ok   <= 1'b1;
                        end else if (rx_ch && left_ok) begin
                            rx_left_q  <= left_hold;
                            rx_right_q <= rx_word;
                            rx_valid_q <= 1'b1;
                            left_ok    <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign bus.rx_left  = rx_left_q;
    assign bus.rx_right = rx_right_q;
    assign bus.rx_valid = rx_valid_q;

    logic [DATA_WIDTH-1:0] tx_buf_r;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [CW-1:0]         tx_cnt;

    // The left sample goes straight into the shifter; only the right one needs buffering for half a frame.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            tx_buf_r <= '0;
            tx_sr    <= '0;
            tx_cnt   <= '0;
            sdout    <= 1'b0;
        end else if (fall) begin
            if (lr_chg) begin
                tx_cnt <= '0;
                sdout  <= 1'b0;
                if (!lrclk) begin
                    tx_buf_r <= bus.tx_right;
                    tx_sr    <= bus.tx_left;
                end else begin
                    tx_sr <= tx_buf_r;
                end
            end else if (tx_cnt < CNT_LAST) begin
                sdout  <= tx_sr[DATA_WIDTH-1];
                tx_sr  <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
                tx_cnt <= tx_cnt + CNT_ONE;
            end else begin
                sdout <= 1'b0;
            end
        end
    end

    // Samples are taken on the edge that closes the left-start cycle, so the pulse marks that cycle.
    assign bus.tx_ready = left_start;

endmodule

// File: tb/tb_i2s_transceiver.sv
// Directed/randomised loopback bench for i2s_transceiver with a stream-level reference of the I2S slot format.
module tb_i2s_transceiver;
    localparam int DW = 24;

    logic mclk = 1'b0;
    logic rst;
    logic sclk;
    logic lrclk;
    logic sdin;
    logic sdout;

    i2s_transceiver_if #(.DATA_WIDTH(DW)) bus ();

    i2s_transceiver #(.DATA_WIDTH(DW), .SLOT_WIDTH(32)) dut (
        .mclk  (mclk),
        .rst   (rst),
        .sclk  (sclk),
        .lrclk (lrclk),
        .sdin  (sdin),
        .sdout (sdout),
        .bus   (bus)
    );

    always #5 mclk = ~mclk;

    // Divider model: sclk = mclk/8, lrclk toggles on an sclk fall every half_len sclk periods.
    logic [2:0] ph        = 3'd0;
    logic [5:0] bitn      = 6'd0;
    logic       lr_r      = 1'b1;
    logic [5:0] half_len  = 6'd32;
    logic       short_req = 1'b0;
    int         cyc       = 0;

    always @(posedge mclk) begin
        cyc <= cyc + 1;
        ph  <= ph + 3'd1;
        if (ph == 3'd7) begin
            if (bitn == half_len - 6'd1) begin
                bitn     <= 6'd0;
                lr_r     <= ~lr_r;
                half_len <= (lr_r && short_req) ? 6'd16 : 6'd32;
            end else begin
                bitn <= bitn + 6'd1;
            end
        end
    end

    assign sclk  = ph[2];
    assign lrclk = lr_r;
    assign sdin  = sdout;

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] slot_word(input logic [DW-1:0] s);
        return {1'b0, s, 7'b0};
    endfunction

    // Stream-level monitor: expected slot contents, tx_ready placement, sdout stability.
    logic            sclk_q = 1'b0, lrclk_q = 1'b1, sdout_q = 1'b0, rst_q = 1'b1, fall_q = 1'b0;
    logic            lr_rise = 1'b1, exp_valid = 1'b0;
    logic [31:0]     hw = '0, last_left_word = '0;
    logic [DW-1:0]   cur_l = '0, cur_r = '0;
    int              hw_cnt = 0, halves = 0, hw_bad = 0, txr_bad = 0, sd_bad = 0, pre_bad = 0;

    always @(negedge mclk) begin
        sclk_q  <= sclk;
        lrclk_q <= lrclk;
        sdout_q <= sdout;
        rst_q   <= rst;
        fall_q  <= !sclk && sclk_q;
        if (bus.tx_ready !== (!rst && !sclk && sclk_q && !lrclk && lrclk_q)) txr_bad <= txr_bad + 1;
        if (!rst && !rst_q && sdout !== sdout_q && !fall_q) sd_bad <= sd_bad + 1;
        if (!rst && !exp_valid && sdout !== 1'b0) pre_bad <= pre_bad + 1;
        if (rst) begin
            exp_valid <= 1'b0;
        end else if (bus.tx_ready === 1'b1) begin
            exp_valid <= 1'b1;
            cur_l     <= bus.tx_left;
            cur_r     <= bus.tx_right;
        end
        if (sclk && !sclk_q) begin
            lr_rise <= lrclk;
            if (lrclk !== lr_rise) begin
                hw     <= {31'b0, sdout};
                hw_cnt <= 1;
            end else if (hw_cnt < 32) begin
                hw     <= {hw[30:0], sdout};
                hw_cnt <= hw_cnt + 1;
                if (hw_cnt == 31 && exp_valid) begin
                    halves <= halves + 1;
                    if ({hw[30:0], sdout} !== slot_word(lrclk ? cur_r : cur_l)) hw_bad <= hw_bad + 1;
                    if (!lrclk) last_left_word <= {hw[30:0], sdout};
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tx(output bit ok, output int t, output int rx_seen);
        ok = 1'b0;
        t = 0;
        rx_seen = 0;
        for (int i = 0; i < 1200 && !ok; i++) begin
            @(negedge mclk);
            if (bus.rx_valid === 1'b1) rx_seen++;
            if (bus.tx_ready === 1'b1) begin
                ok = 1'b1;
                t = cyc;
            end
        end
    endtask

    task automatic wait_rx(output bit ok, output int t);
        ok = 1'b0;
        t = 0;
        for (int i = 0; i < 700 && !ok; i++) begin
            @(negedge mclk);
            if (bus.rx_valid === 1'b1) begin
                ok = 1'b1;
                t = cyc;
            end
        end
    endtask

    int last_tx_t = 0;
    int last_rx_t = 0;
    logic [DW-1:0] last_l = '0, last_r = '0;

    // Called just after the tx_ready cycle: scramble the inputs, then expect the pair back.
    task automatic finish_frame(input string tag, input logic [DW-1:0] l, input logic [DW-1:0] r,
                                input int t_tx, input bit chk_period);
        bit ok;
        int t;
        @(posedge mclk);
        #1;
        bus.tx_left  = DW'($urandom);
        bus.tx_right = DW'($urandom);
        wait_rx(ok, t);
        check({tag, "_rx_timeout"}, {31'b0, ok}, 32'd1);
        check({tag, "_rx_left"}, {8'b0, bus.rx_left}, {8'b0, l});
        check({tag, "_rx_right"}, {8'b0, bus.rx_right}, {8'b0, r});
        check({tag, "_rx_latency"}, t - t_tx, 32'd453);
        if (chk_period) check({tag, "_rx_period"}, t - last_rx_t, 32'd512);
        last_rx_t = t;
        last_l = l;
        last_r = r;
        @(negedge mclk);
        check({tag, "_rx_pulse_width"}, {31'b0, bus.rx_valid}, 32'd0);
    endtask

    task automatic do_frame(input string tag, input logic [DW-1:0] l, input logic [DW-1:0] r,
                            input bit chk_period);
        bit ok;
        int t, n;
        bus.tx_left  = l;
        bus.tx_right = r;
        wait_tx(ok, t, n);
        check({tag, "_tx_timeout"}, {31'b0, ok}, 32'd1);
        check({tag, "_stray_rx"}, n, 32'd0);
        if (chk_period) check({tag, "_tx_period"}, t - last_tx_t, 32'd512);
        last_tx_t = t;
        finish_frame(tag, l, r, t, chk_period);
    endtask

    initial begin
        bit ok;
        int t1, t2, n;
        logic [DW-1:0] sl, sr, cl, cr;

        rst = 1'b1;
        bus.tx_left  = '0;
        bus.tx_right = '0;
        repeat (4) @(negedge mclk);
        check("rst_sdout", {31'b0, sdout}, 32'd0);
        check("rst_tx_ready", {31'b0, bus.tx_ready}, 32'd0);
        check("rst_rx_valid", {31'b0, bus.rx_valid}, 32'd0);
        check("rst_rx_left", {8'b0, bus.rx_left}, 32'd0);
        check("rst_rx_right", {8'b0, bus.rx_right}, 32'd0);

        for (int i = 0; i < 600; i++) begin
            @(negedge mclk);
            if (bitn == 6'd10) break;
        end
        rst = 1'b0;

        do_frame("bit", 24'h800001, DW'($urandom), 1'b0);
        check("bit_left_slot", last_left_word, 32'h40000080);

        for (int i = 0; i < 5; i++) do_frame("rand", DW'($urandom), DW'($urandom), 1'b1);

        for (int i = 0; i < 4; i++)
            do_frame("sign", (i % 2 == 1) ? 24'h800000 : 24'h7FFFFF,
                     (i % 2 == 1) ? 24'hFFFFFF : 24'h000000, 1'b1);

        // Short left half: that frame must produce no rx_valid and leave rx outputs alone.
        sl = DW'($urandom);
        sr = DW'($urandom);
        cl = DW'($urandom);
        cr = DW'($urandom);
        short_req = 1'b1;
        bus.tx_left  = sl;
        bus.tx_right = sr;
        wait_tx(ok, t1, n);
        check("short_tx_timeout", {31'b0, ok}, 32'd1);
        @(posedge mclk);
        #1;
        short_req = 1'b0;
        bus.tx_left  = cl;
        bus.tx_right = cr;
        wait_tx(ok, t2, n);
        check("short_next_tx_timeout", {31'b0, ok}, 32'd1);
        check("short_no_valid", n, 32'd0);
        check("short_frame_len", t2 - t1, 32'd384);
        check("short_hold_left", {8'b0, bus.rx_left}, {8'b0, last_l});
        check("short_hold_right", {8'b0, bus.rx_right}, {8'b0, last_r});
        last_tx_t = t2;
        finish_frame("after_short", cl, cr, t2, 1'b0);

        // Reset in the middle of a right-channel capture.
        for (int i = 0; i < 1200; i++) begin
            @(negedge mclk);
            if (lrclk && bitn == 6'd10) break;
        end
        rst = 1'b1;
        #1;
        check("mid_rst_sdout", {31'b0, sdout}, 32'd0);
        check("mid_rst_tx_ready", {31'b0, bus.tx_ready}, 32'd0);
        check("mid_rst_rx_valid", {31'b0, bus.rx_valid}, 32'd0);
        check("mid_rst_rx_left", {8'b0, bus.rx_left}, 32'd0);
        check("mid_rst_rx_right", {8'b0, bus.rx_right}, 32'd0);
        repeat (3) @(negedge mclk);
        rst = 1'b0;
        cl = DW'($urandom);
        cr = DW'($urandom);
        bus.tx_left  = cl;
        bus.tx_right = cr;
        wait_tx(ok, t1, n);
        check("resync_tx_timeout", {31'b0, ok}, 32'd1);
        check("resync_no_valid", n, 32'd0);
        last_tx_t = t1;
        finish_frame("resync", cl, cr, t1, 1'b0);

        repeat (4) @(negedge mclk);
        check("slot_stream_errors", hw_bad, 32'd0);
        check("slot_halves_seen", {31'b0, halves >= 20}, 32'd1);
        check("tx_ready_placement_errors", txr_bad, 32'd0);
        check("sdout_stability_errors", sd_bad, 32'd0);
        check("sdout_before_start_errors", pre_bad, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2s_transceiver.md
Name: i2s_transceiver

Overview:
- Serial audio datapath stage fed by i2s_clock_divider: consumes its sclk/lrclk and runs entirely in the mclk domain.
- Deserialises ADC data (sdin) into parallel left/right samples.
- Serialises parallel DAC samples onto sdout.
- Format: Philips I2S (MSB first, one-bit delay after lrclk edge, lrclk low = left), 32-bit slots, 64 sclk per frame, 512 mclk per frame.

Parameters:
- DATA_WIDTH, 24, sample bits per channel; must be ≤ SLOT_WIDTH-1.
- SLOT_WIDTH, 32, sclk periods per lrclk half; used for bounds checks only.

Ports:
- mclk  in  1  master clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- sclk  in  1  serial clock from divider, mclk-synchronous, no synchroniser.
- lrclk  in  1  word select from divider, mclk-synchronous; 0 = left, 1 = right.
- sdin  in  1  ADC serial data.
- sdout  out  1  DAC serial data.
- tx_left  in  DATA_WIDTH  DAC left sample, two's complement.
- tx_right  in  DATA_WIDTH  DAC right sample, two's complement.
- tx_ready  out  1  one-mclk pulse: tx_left/tx_right sampled this cycle.
- rx_left  out  DATA_WIDTH  last complete ADC left sample.
- rx_right  out  DATA_WIDTH  last complete ADC right sample.
- rx_valid  out  1  one-mclk pulse: rx_left/rx_right updated this cycle.

Behaviour:
- Reset values: sdout=0, tx_ready=0, rx_left=0, rx_right=0, rx_valid=0. All shift registers, counters and sync flags are cleared.
- Edge detect: sclk_d/lrclk_d registered each mclk.
  - rise = sclk & ~sclk_d; fall = ~sclk & sclk_d; lr_chg = lrclk ^ lrclk_d.
  - The divider changes lrclk on the same mclk edge as an sclk fall, so lr_chg coincides with fall.
- RX, acting on sclk rise only:
  - rx_lr is the lrclk value seen at the previous rise.
  - If lrclk != rx_lr, this rise is the delay bit: rx_cnt←1, data ignored, channel = lrclk.
  - Otherwise, while 1 ≤ rx_cnt ≤ DATA_WIDTH, shift sdin into rx_sr LSB (MSB arrives first) and increment rx_cnt.
  - rx_cnt saturates at DATA_WIDTH+1; bits beyond are ignored.
  - On the rise that captures bit DATA_WIDTH:
    - Left: value goes to the internal left_hold register.
    - Right: if left_hold is valid for this frame, rx_left←left_hold and rx_right←new word in the same cycle; rx_valid=1 on the following mclk.
- RX sync: rx_synced is cleared at reset and set at the first left-channel delay bit. No rx_valid until a full left then right pair has been captured after sync.
- RX short slot: if a channel change occurs before DATA_WIDTH bits are captured, that half is discarded.
  - A discarded left suppresses that frame's rx_valid.
  - rx_left/rx_right hold their previous values.
- TX, acting on sclk fall only:
  - Fall with lr_chg and lrclk=0 (left start): latch tx_left/tx_right into tx_buf_l/tx_buf_r, tx_ready=1 for that one mclk cycle, tx_sr←tx_buf_l (newly latched value), tx_cnt←0, sdout←0 (delay bit).
  - Fall with lr_chg and lrclk=1 (right start): tx_sr←tx_buf_r, tx_cnt←0, sdout←0.
  - Other falls: if tx_cnt < DATA_WIDTH, sdout←tx_sr MSB, shift left, tx_cnt+1; else sdout←0 (pad to slot end).
  - Net effect: the channel MSB is valid at the 2nd sclk rise after the lrclk edge.
- sdout changes only on mclk cycles flagged fall; it is stable across every sclk rise.
- tx_ready period is exactly 512 mclk once the divider is running. The upstream block must hold tx_left/tx_right valid at the pulse.
- Before the first lrclk edge after reset, sdout=0 and tx_ready never pulses.
- Reset mid-frame: immediate clear. Operation resumes cleanly at the next lrclk falling transition (left start); partial data is never emitted.
- rx_valid and tx_ready are independent and may assert in the same cycle.

Test Plan:
- Reset: assert rst mid-frame with the divider running -> all outputs 0 within the same cycle. After release, first tx_ready at the first left-start fall; first rx_valid no earlier than a full frame later.
- Loopback: sdout→sdin, tx_left=24'h123456, tx_right=24'hABCDEF -> rx_left=24'h123456, rx_right=24'hABCDEF. rx_valid pulses single-cycle, exactly 512 mclk apart.
- TX bit timing: tx_left=24'h800001 -> sdout=0 at the delay bit, 1 at the MSB (2nd rise after lrclk fall), 0 for bits 22..1, 1 at the LSB, 0 for the 7 pad bits.
- Sign extremes: alternate frames tx_left=24'h7FFFFF/24'h800000, tx_right=0/24'hFFFFFF -> exact loopback match each frame; tx_ready samples the new values each frame.
- Short slot: a custom bench drives lrclk toggling after 16 sclk in one left half -> no rx_valid for that frame, rx outputs unchanged; the next normal frame resumes with rx_valid.
- Reset mid right-channel capture -> no rx_valid until a full left+right pair after re-sync; the first pair matches the transmitted data.
